// File: rtl/exu_iterative_divider_pkg.sv
// rtl/exu_iterative_divider_pkg.sv - shared constants, state encoding and helpers for the iterative divider
package exu_iterative_divider_pkg;

    localparam int XLEN   = 64;
    localparam int ITER_D = 64;
    localparam int ITER_W = 32;

    localparam logic [63:0] MOST_NEG_64 = 64'h8000_0000_0000_0000;
    localparam logic [31:0] MOST_NEG_32 = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

endpackage

// File: rtl/exu_iterative_divider_div_restoring_step.sv
// rtl/exu_iterative_divider_div_restoring_step.sv - one combinational restoring shift/trial-subtract iteration
module div_restoring_step
    import exu_iterative_divider_pkg::*;
(
    input  logic [2*XLEN:0]   part_rem_i,
    input  logic [XLEN-1:0]   divisor_i,
    output logic [2*XLEN-1:0] part_rem_o,
    output logic              q_bit_o
);

    // part_rem_o is bits [2*XLEN:1] of the next partial remainder; q_bit_o is its bit 0.
    logic [XLEN+1:0] upper;
    logic [XLEN+1:0] trial;

    assign upper      = part_rem_i[2*XLEN:XLEN-1];
    assign trial      = upper - {2'b00, divisor_i};
    assign q_bit_o    = ~trial[XLEN+1];
    assign part_rem_o = q_bit_o ? {trial[XLEN:0], part_rem_i[XLEN-2:0]}
                                : part_rem_i[2*XLEN-1:0];

endmodule

// File: rtl/exu_iterative_divider.sv
// rtl/exu_iterative_divider.sv - RV64M iterative restoring divider (DIV/DIVU/REM/REMU and W forms)
// Optional build macro DIV_EARLY_OUT_EN: finish immediately when |dividend| < |divisor|.
module exu_iterative_divider
    import exu_iterative_divider_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            io_div_valid,
    input  logic            io_flush,
    input  logic            io_divw,
    input  logic            io_div_signed,
    input  logic [XLEN-1:0] io_dividend,
    input  logic [XLEN-1:0] io_divisor,
    output logic            io_div_ready,
    output logic            io_out_valid,
    output logic [XLEN-1:0] io_quotient,
    output logic [XLEN-1:0] io_remainder
);

    localparam int PW = 2*XLEN + 1;

    div_state_e      state_q, state_d;
    logic [6:0]      count_q, count_d;
    logic [PW-1:0]   part_q, part_d;
    logic [XLEN-1:0] dvs_mag_q, dvs_mag_d;
    logic            divw_q, divw_d;
    logic            neg_quot_q, neg_quot_d;
    logic            neg_rem_q, neg_rem_d;
    logic [XLEN-1:0] quotient_q, quotient_d;
    logic [XLEN-1:0] remainder_q, remainder_d;

    logic [XLEN-1:0] dvd_eff, dvs_eff, dvd_mag, dvs_mag, dvd_res;
    logic            dvd_neg, dvs_neg, div_zero, overflow, early_out;

    logic [2*XLEN-1:0] step_hi;
    logic              step_qbit;
    logic [PW-1:0]     next_part;
    logic [XLEN-1:0]   q_raw, r_raw, q_fix, r_fix, q_final, r_final;
    logic [6:0]        last_count;

    div_restoring_step u_step (
        .part_rem_i (part_q),
        .divisor_i  (dvs_mag_q),
        .part_rem_o (step_hi),
        .q_bit_o    (step_qbit)
    );

    // Operand preparation on the request inputs, used only at accept.
    always_comb begin
        if (io_divw) begin
            dvd_eff = io_div_signed ? sext32(io_dividend[31:0]) : {32'b0, io_dividend[31:0]};
            dvs_eff = io_div_signed ? sext32(io_divisor[31:0])  : {32'b0, io_divisor[31:0]};
            dvd_res = sext32(io_dividend[31:0]);
        end else begin
            dvd_eff = io_dividend;
            dvs_eff = io_divisor;
            dvd_res = io_dividend;
        end
        dvd_neg  = io_div_signed & dvd_eff[XLEN-1];
        dvs_neg  = io_div_signed & dvs_eff[XLEN-1];
        dvd_mag  = dvd_neg ? -dvd_eff : dvd_eff;
        dvs_mag  = dvs_neg ? -dvs_eff : dvs_eff;
        div_zero = (dvs_eff == '0);
        if (io_divw)
            overflow = io_div_signed && (io_dividend[31:0] == MOST_NEG_32)
                       && (io_divisor[31:0] == 32'hFFFF_FFFF);
        else
            overflow = io_div_signed && (io_dividend == MOST_NEG_64)
                       && (io_divisor == {XLEN{1'b1}});
`ifdef DIV_EARLY_OUT_EN
        early_out = (dvd_mag < dvs_mag);
`else
        early_out = 1'b0;
`endif
    end

    // Sign/width correction of the iteration result as it completes.
    always_comb begin
        next_part  = {step_hi, step_qbit};
        q_raw      = divw_q ? {32'b0, next_part[31:0]} : next_part[XLEN-1:0];
        r_raw      = next_part[2*XLEN-1:XLEN];
        q_fix      = neg_quot_q ? -q_raw : q_raw;
        r_fix      = neg_rem_q  ? -r_raw : r_raw;
        q_final    = divw_q ? sext32(q_fix[31:0]) : q_fix;
        r_final    = divw_q ? sext32(r_fix[31:0]) : r_fix;
        last_count = divw_q ? 7'(ITER_W - 1) : 7'(ITER_D - 1);
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        part_d      = part_q;
        dvs_mag_d   = dvs_mag_q;
        divw_d      = divw_q;
        neg_quot_d  = neg_quot_q;
        neg_rem_d   = neg_rem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;

        case (state_q)
            ST_IDLE: begin
                if (io_div_valid) begin
                    divw_d     = io_divw;
                    neg_quot_d = dvd_neg ^ dvs_neg;
                    neg_rem_d  = dvd_neg;
                    dvs_mag_d  = dvs_mag;
                    count_d    = '0;
                    // W dividends start 32 bits higher so 32 shifts bring them fully into the upper half.
                    part_d     = io_divw ? {65'b0, dvd_mag[31:0], 32'b0} : {65'b0, dvd_mag};
                    if (div_zero) begin
                        quotient_d  = {XLEN{1'b1}};
                        remainder_d = dvd_res;
                        state_d     = ST_DONE;
                    end else if (overflow) begin
                        quotient_d  = dvd_res;
                        remainder_d = '0;
                        state_d     = ST_DONE;
                    end else if (early_out) begin
                        quotient_d  = '0;
                        remainder_d = dvd_res;
                        state_d     = ST_DONE;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (io_flush) begin
                    state_d = ST_IDLE;
                end else begin
                    part_d  = next_part;
                    count_d = count_q + 7'd1;
                    if (count_q == last_count) begin
                        quotient_d  = q_final;
                        remainder_d = r_final;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            part_q      <= '0;
            dvs_mag_q   <= '0;
            divw_q      <= 1'b0;
            neg_quot_q  <= 1'b0;
            neg_rem_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            part_q      <= part_d;
            dvs_mag_q   <= dvs_mag_d;
            divw_q      <= divw_d;
            neg_quot_q  <= neg_quot_d;
            neg_rem_q   <= neg_rem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign io_div_ready = (state_q == ST_IDLE);
    assign io_out_valid = (state_q == ST_DONE);
    assign io_quotient  = quotient_q;
    assign io_remainder = remainder_q;

endmodule

// File: tb/tb_exu_iterative_divider.sv
// tb/tb_exu_iterative_divider.sv - scoreboard bench for exu_iterative_divider (honours DIV_EARLY_OUT_EN)
module tb_exu_iterative_divider;

`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        div_valid = 1'b0;
    logic        flush = 1'b0;
    logic        divw = 1'b0;
    logic        div_signed = 1'b0;
    logic [63:0] dividend = '0;
    logic [63:0] divisor = '0;
    logic        div_ready;
    logic        out_valid;
    logic [63:0] quotient;
    logic [63:0] remainder;

    exu_iterative_divider dut (
        .clock         (clock),
        .reset         (reset),
        .io_div_valid  (div_valid),
        .io_flush      (flush),
        .io_divw       (divw),
        .io_div_signed (div_signed),
        .io_dividend   (dividend),
        .io_divisor    (divisor),
        .io_div_ready  (div_ready),
        .io_out_valid  (out_valid),
        .io_quotient   (quotient),
        .io_remainder  (remainder)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        int          lat;
        int          t0;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [63:0] last_q = '0;
    logic [63:0] last_r = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && out_valid) begin
            if (sb.size() == 0) begin
                check("spurious_out_valid", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("quotient", quotient, mon_e.q);
                check("remainder", remainder, mon_e.r);
                check("latency", 64'(cyc - mon_e.t0), 64'(mon_e.lat));
                last_q = mon_e.q;
                last_r = mon_e.r;
            end
        end
    end

    function automatic void ref_div(input logic dw, input logic sg, input logic [63:0] a,
                                    input logic [63:0] b, output logic [63:0] q,
                                    output logic [63:0] r, output int lat);
        logic [31:0] a32, b32, q32, r32;
        logic [63:0] ae, be, am, bm;
        logic        special;
        a32 = a[31:0];
        b32 = b[31:0];
        ae = dw ? (sg ? {{32{a32[31]}}, a32} : {32'b0, a32}) : a;
        be = dw ? (sg ? {{32{b32[31]}}, b32} : {32'b0, b32}) : b;
        am = (sg && ae[63]) ? -ae : ae;
        bm = (sg && be[63]) ? -be : be;
        if (dw) begin
            if (b32 == 0) begin
                q32 = 32'hFFFF_FFFF; r32 = a32;
            end else if (sg && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32; r32 = 32'd0;
            end else if (sg) begin
                q32 = 32'($signed(a32) / $signed(b32));
                r32 = 32'($signed(a32) % $signed(b32));
            end else begin
                q32 = a32 / b32; r32 = a32 % b32;
            end
            q = {{32{q32[31]}}, q32};
            r = {{32{r32[31]}}, r32};
            special = (b32 == 0) || (sg && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF);
        end else begin
            if (b == 0) begin
                q = '1; r = a;
            end else if (sg && a == 64'h8000_0000_0000_0000 && b == '1) begin
                q = a; r = '0;
            end else if (sg) begin
                q = 64'($signed(a) / $signed(b));
                r = 64'($signed(a) % $signed(b));
            end else begin
                q = a / b; r = a % b;
            end
            special = (b == 0) || (sg && a == 64'h8000_0000_0000_0000 && b == '1);
        end
        lat = special ? 1 : ((EARLY && am < bm) ? 1 : (dw ? 33 : 65));
    endfunction

    // Called just after a negedge; returns at the negedge following acceptance.
    task automatic do_op(input logic dw, input logic sg, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] eq, input logic [63:0] er, input int lat, input bit push);
        int guard;
        guard = 0;
        while (!div_ready && guard < 300) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 300) check("ready_timeout", 64'(guard), 64'd0);
        divw = dw; div_signed = sg; dividend = a; divisor = b; div_valid = 1'b1;
        if (push) sb.push_back('{eq, er, lat, cyc});
        @(negedge clock);
        div_valid  = 1'b0;
        dividend   = {$urandom(), $urandom()};
        divisor    = {$urandom(), $urandom()};
        divw       = 1'($urandom());
        div_signed = 1'($urandom());
    endtask

    task automatic rand_op(input int sel);
        logic        dw, sg;
        logic [63:0] a, b, q, r;
        int          lat;
        dw = 1'($urandom()); sg = 1'($urandom());
        a = {$urandom(), $urandom()};
        b = {$urandom(), $urandom()};
        case (sel)
            1: begin
                b = 64'($urandom_range(1, 1000));
                if ($urandom_range(0, 1) == 1) b = -b;
            end
            2: b = '0;
            3: a = 64'($urandom_range(0, 50));
            default: ;
        endcase
        ref_div(dw, sg, a, b, q, r, lat);
        do_op(dw, sg, a, b, q, r, lat, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        int cnt;
        repeat (3) @(negedge clock);
        check("rst_ready", 64'(div_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_quotient", quotient, 64'd0);
        check("rst_remainder", remainder, 64'd0);
        reset = 1'b0;
        @(negedge clock);

        do_op(1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 65, 1'b1);
        cnt = 0;
        while (!div_ready && cnt < 200) begin
            cnt++;
            @(negedge clock);
        end
        check("ready_low_cycles", 64'(cnt), 64'd65);

        do_op(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
              64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65, 1'b1);

        for (int m = 0; m < 4; m++)
            do_op((m / 2) == 1, (m % 2) == 1, 64'd5, 64'd0, '1, 64'd5, 1, 1'b1);
        do_op(1'b1, 1'b0, 64'h0000_0000_8000_0001, 64'd0, '1, 64'hFFFF_FFFF_8000_0001, 1, 1'b1);

        do_op(1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              64'h8000_0000_0000_0000, 64'd0, 1, 1'b1);
        do_op(1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
              64'hFFFF_FFFF_8000_0000, 64'd0, 1, 1'b1);

        do_op(1'b1, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, 64'd1, 33, 1'b1);

        do_op(1'b0, 1'b0, 64'd3, 64'd10, 64'd0, 64'd3, EARLY ? 1 : 65, 1'b1);

        // Flush at T+10; a fresh request is accepted at T+11.
        do_op(1'b0, 1'b0, 64'd1000, 64'd3, 64'd0, 64'd0, 65, 1'b0);
        repeat (9) @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        check("flush_ready", 64'(div_ready), 64'd1);
        check("flush_hold_q", quotient, last_q);
        check("flush_hold_r", remainder, last_r);
        do_op(1'b0, 1'b0, 64'd20, 64'd3, 64'd6, 64'd2, 65, 1'b1);

        for (int i = 0; i < 16; i++) rand_op(i % 4);

        // Reset in the middle of a divide.
        do_op(1'b0, 1'b1, 64'd12345, 64'd7, 64'd0, 64'd0, 65, 1'b0);
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_ready", 64'(div_ready), 64'd1);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_quotient", quotient, 64'd0);
        check("midrst_remainder", remainder, 64'd0);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
